fib_arbiter: RTL and testbench
==============================

FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 Parameter NUM_CL, default 4, number of client ports (2..8).
REQ-002 Parameter N_IN, default 7, width of each client index n.
REQ-003 Parameter N_OUT, default 90, width of result.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 cl_req  input  NUM_CL  per-client request, four-phase level.
REQ-007 cl_n  input  NUM_CL*N_IN  per-client Fibonacci index; client i at bits [i*N_IN +: N_IN]; stable while cl_req[i]=1.
REQ-008 cl_ack  output  NUM_CL  per-client acknowledge; at most one bit set.
REQ-009 cl_result  output  N_OUT  shared result; valid while any cl_ack bit is 1.
REQ-010 fib_req  output  1  request to the shared Fibonacci engine.
REQ-011 fib_n  output  N_IN  index to the engine, held while fib_req=1.
REQ-012 fib_ack  input  1  engine acknowledge; stays 1 after completion until the engine accepts the next request.
REQ-013 fib_result  input  N_OUT  engine result, valid when fib_ack=1.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_DONE, RELEASE, LOCAL.
REQ-016 IDLE: when any cl_req bit is 1, grant the first requesting client at or after rr_ptr (round-robin, wrapping NUM_CL-1 -> 0), latch grant index and cl_n of the winner.
REQ-017 IDLE with latched n==0 SHALL go to LOCAL (engine not used); otherwise go to ISSUE with fib_req=1 and fib_n=latched n.
REQ-018 ISSUE: hold fib_req=1; ignore fib_ack until it is sampled 0 (stale ack from previous transaction), then go to WAIT_DONE.
REQ-019 WAIT_DONE: on fib_ack=1 capture fib_result into cl_result, drive fib_req=0, set cl_ack[grant]=1, go to RELEASE.
REQ-020 LOCAL: set cl_result=0, cl_ack[grant]=1, go to RELEASE; latency 2 cycles from cl_req sample.
REQ-021 RELEASE: hold cl_ack[grant]=1 and cl_result until cl_req[grant] sampled 0; then clear cl_ack, set rr_ptr=grant+1 mod NUM_CL, go to IDLE.
REQ-022 fib_req SHALL remain 0 for at least 2 consecutive cycles between engine transactions.
REQ-023 Requests from non-granted clients SHALL be held pending with no effect until IDLE; changes of cl_n[grant] after latch SHALL be ignored.
REQ-024 A client dropping cl_req before its ack SHALL NOT abort the transaction; ack SHALL be issued, then removed one cycle later in RELEASE.
REQ-025 cl_result SHALL change only on entry to RELEASE.
REQ-026 Latency n>=1: cl_ack rises engine-latency + 3 cycles after cl_req is sampled in IDLE.

Reset
REQ-027 On rst_n=0, immediately: state=IDLE, cl_ack=0, cl_result=0, fib_req=0, fib_n=0, busy=0, rr_ptr=0, grant=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no ack issued; the engine is reset by the same rst_n.
REQ-029 First grant after reset SHALL go to the lowest-index requester.

Verification
REQ-030 Single client 0, n=10 -> one fib_req pulse with fib_n=10; cl_ack[0]=1, cl_result=55; cl_ack clears one cycle after cl_req[0] drops.
REQ-031 Clients 0..3 all request simultaneously after reset with n=1,2,3,90 -> served in order 0,1,2,3 with results 1,1,2,2880067194370816120.
REQ-032 Client 2 requests repeatedly with client 1 constant -> grants strictly alternate 1,2,1,2.
REQ-033 Client 3, n=0 -> fib_req stays 0, cl_ack[3]=1 with cl_result=0 two cycles after request.
REQ-034 Back-to-back transactions -> second ISSUE does not complete on stale fib_ack=1; result equals second index's value.
REQ-035 rst_n asserted during WAIT_DONE -> all outputs 0 at once; subsequent request n=5 returns 5.

Source files
------------

// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one Fibonacci engine among NUM_CL four-phase clients.
// Latency: n==0 answered locally (ack 2 cycles after request); n>=1 costs engine latency plus handshake cycles.
// Backpressure: losing clients stay pending untouched; the granted client holds the arbiter in RELEASE until it drops cl_req.
module fib_arbiter #(
    parameter int NUM_CL = 4,
    parameter int N_IN   = 7,
    parameter int N_OUT  = 90
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CL-1:0]        cl_req,
    input  logic [NUM_CL*N_IN-1:0]   cl_n,
    output logic [NUM_CL-1:0]        cl_ack,
    output logic [N_OUT-1:0]         cl_result,
    output logic                     fib_req,
    output logic [N_IN-1:0]          fib_n,
    input  logic                     fib_ack,
    input  logic [N_OUT-1:0]         fib_result,
    output logic                     busy
);

    localparam int GW = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RELEASE,
        LOCAL
    } state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant, grant_nxt;
    logic [GW-1:0]       rr_ptr, rr_nxt;
    logic [NUM_CL-1:0]   ack_nxt;
    logic [N_OUT-1:0]    res_nxt;
    logic                fib_req_nxt;
    logic [N_IN-1:0]     fib_n_nxt;

    logic                win_vld;
    logic [GW-1:0]       win_idx;
    logic [N_IN-1:0]     win_n;
    logic [GW-1:0]       cand;
    int                  sum;
    logic [N_IN-1:0]     n_arr [NUM_CL];

    for (genvar i = 0; i < NUM_CL; i++) begin : g_split
        assign n_arr[i] = cl_n[i*N_IN +: N_IN];
    end

    assign win_n = n_arr[win_idx];
    assign busy  = (state != IDLE);

    // Round-robin pick: scan from rr_ptr downwards in priority so the nearest requester at/after rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = 0;
        cand    = '0;
        for (int k = NUM_CL - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_CL) begin
                sum = sum - NUM_CL;
            end
            cand = GW'(sum);
            if (cl_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state and registered-output decode; every register holds unless its state says otherwise.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_nxt      = rr_ptr;
        ack_nxt     = cl_ack;
        res_nxt     = cl_result;
        fib_req_nxt = fib_req;
        fib_n_nxt   = fib_n;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_nxt = win_idx;
                    fib_n_nxt = win_n;
                    if (win_n == '0) begin
                        state_nxt = LOCAL;
                    end else begin
                        state_nxt   = ISSUE;
                        fib_req_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // A high fib_ack here is left over from the previous transaction.
                if (!fib_ack) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (fib_ack) begin
                    res_nxt        = fib_result;
                    fib_req_nxt    = 1'b0;
                    ack_nxt        = '0;
                    ack_nxt[grant] = 1'b1;
                    state_nxt      = RELEASE;
                end
            end
            LOCAL: begin
                res_nxt        = '0;
                ack_nxt        = '0;
                ack_nxt[grant] = 1'b1;
                state_nxt      = RELEASE;
            end
            RELEASE: begin
                if (!cl_req[grant]) begin
                    ack_nxt   = '0;
                    rr_nxt    = (grant == GW'(NUM_CL - 1)) ? '0 : grant + 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            cl_ack    <= '0;
            cl_result <= '0;
            fib_req   <= 1'b0;
            fib_n     <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            cl_ack    <= ack_nxt;
            cl_result <= res_nxt;
            fib_req   <= fib_req_nxt;
            fib_n     <= fib_n_nxt;
        end
    end

endmodule

// File: tb/tb_fib_arbiter.sv
// Testbench for fib_arbiter: behavioural engine, Fibonacci/round-robin reference, directed and random client traffic.
// Inputs driven and outputs sampled on the falling edge.
// Clients follow the four-phase protocol and drop cl_req only after being acknowledged, except where a test drops early.
module tb_fib_arbiter;

    localparam int NUM_CL = 4;
    localparam int N_IN   = 7;
    localparam int N_OUT  = 90;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CL-1:0]      cl_req;
    logic [NUM_CL*N_IN-1:0] cl_n;
    logic [NUM_CL-1:0]      cl_ack;
    logic [N_OUT-1:0]       cl_result;
    logic                   fib_req;
    logic [N_IN-1:0]        fib_n;
    logic                   fib_ack;
    logic [N_OUT-1:0]       fib_result;
    logic                   busy;

    always #5 clk = ~clk;

    fib_arbiter #(.NUM_CL(NUM_CL), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cl_req     (cl_req),
        .cl_n       (cl_n),
        .cl_ack     (cl_ack),
        .cl_result  (cl_result),
        .fib_req    (fib_req),
        .fib_n      (fib_n),
        .fib_ack    (fib_ack),
        .fib_result (fib_result),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [N_OUT-1:0] obs, input logic [N_OUT-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_OUT-1:0] fib(input int n);
        logic [N_OUT-1:0] a, b, t;
        a = '0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int pick(input logic [NUM_CL-1:0] req, input int ptr);
        for (int k = 0; k < NUM_CL; k++) begin
            if (req[(ptr + k) % NUM_CL]) return (ptr + k) % NUM_CL;
        end
        return -1;
    endfunction

    // Behavioural engine: accepts on a rising fib_req, answers eng_lat cycles later, keeps ack high until next accept.
    int               eng_lat = 3;
    int               eng_cnt;
    logic             eng_busy, req_q;
    logic [N_IN-1:0]  eng_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fib_ack    <= 1'b0;
            fib_result <= '0;
            eng_busy   <= 1'b0;
            req_q      <= 1'b0;
            eng_cnt    <= 0;
            eng_n      <= '0;
        end else begin
            req_q <= fib_req;
            if (fib_req && !req_q) begin
                fib_ack  <= 1'b0;
                eng_busy <= 1'b1;
                eng_cnt  <= eng_lat;
                eng_n    <= fib_n;
            end else if (eng_busy) begin
                if (eng_cnt <= 1) begin
                    fib_ack    <= 1'b1;
                    fib_result <= fib(int'(eng_n));
                    eng_busy   <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    // Protocol monitor: one-hot ack, idle gap between engine requests, held fib_n and cl_result.
    int               low_run = 100;
    int               n_pulses = 0;
    logic [N_IN-1:0]  pulse_n = '0;
    logic             ack_at_rise = 1'b0;
    logic             prev_req = 1'b0;
    logic [NUM_CL-1:0] prev_ack = '0;
    logic [N_OUT-1:0] prev_res = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            low_run  = 100;
            prev_req = 1'b0;
            prev_ack = '0;
        end else begin
            chk("ack_onehot", ($countones(cl_ack) <= 1), 1);
            if (fib_req && !prev_req) begin
                chk("fib_req_gap", (low_run >= 2), 1);
                n_pulses++;
                pulse_n     = fib_n;
                ack_at_rise = fib_ack;
            end
            if (fib_req && prev_req) chk("fib_n_hold", fib_n, pulse_n);
            if (cl_ack != '0 && prev_ack != '0) chk("result_hold", cl_result, prev_res);
            low_run  = fib_req ? 0 : low_run + 1;
            prev_req = fib_req;
            prev_ack = cl_ack;
            prev_res = cl_result;
        end
    end

    int mdl_ptr = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_n(input int i, input int v);
        cl_n[i*N_IN +: N_IN] = N_IN'(v);
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (cl_ack != '0) break;
        end
        chk("ack_seen", (cl_ack != '0), 1);
        for (int i = 0; i < NUM_CL; i++) begin
            if (cl_ack[i]) idx = i;
        end
    endtask

    task automatic release_client(input int idx);
        cl_req[idx] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cl_ack == '0) break;
        end
        chk("ack_clear", cl_ack, 0);
    endtask

    // Serve the next client chosen by the round-robin reference and check grant and result.
    task automatic serve_one(input bit do_release, output int idx);
        int exp_idx;
        int exp_n;
        exp_idx = pick(cl_req, mdl_ptr);
        exp_n   = int'(cl_n[exp_idx*N_IN +: N_IN]);
        wait_grant(idx);
        chk("grant_idx", idx, exp_idx);
        chk("result", cl_result, fib(exp_n));
        mdl_ptr = (exp_idx + 1) % NUM_CL;
        if (do_release) release_client(exp_idx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        cl_req = '0;
        tick(2);
        rst_n   = 1'b1;
        mdl_ptr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int p0;
        int exp_seq [4];
        logic [NUM_CL-1:0] mask;
        exp_seq = '{1, 2, 1, 2};
        rst_n  = 1'b0;
        cl_req = '0;
        cl_n   = '0;
        tick(3);
        chk("rst_cl_ack", cl_ack, 0);
        chk("rst_cl_result", cl_result, 0);
        chk("rst_fib_req", fib_req, 0);
        chk("rst_fib_n", fib_n, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(1);

        // Single client 0, n=10.
        p0 = n_pulses;
        set_n(0, 10);
        cl_req[0] = 1'b1;
        serve_one(1'b0, idx);
        chk("single_result55", cl_result, 55);
        chk("single_pulses", n_pulses, p0 + 1);
        chk("single_fib_n", pulse_n, 10);
        cl_req[0] = 1'b0;
        tick(1);
        chk("single_ack_drop_1cyc", cl_ack, 0);
        chk("single_busy_idle", busy, 0);

        // Client 3, n=0: served locally, ack two edges after the request is driven.
        p0 = n_pulses;
        set_n(3, 0);
        cl_req[3] = 1'b1;
        tick(1);
        chk("local_ack_early", cl_ack, 0);
        chk("local_busy", busy, 1);
        tick(1);
        chk("local_ack", cl_ack, 4'b1000);
        chk("local_result", cl_result, 0);
        chk("local_no_fib", n_pulses, p0);
        release_client(3);
        mdl_ptr = 0;

        // Four simultaneous requests after reset.
        do_reset();
        set_n(0, 1);
        set_n(1, 2);
        set_n(2, 3);
        set_n(3, 90);
        cl_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b1, idx);
            chk("all4_order", idx, i);
        end
        chk("fib90", fib(90), 90'd2880067194370816120);

        // Client 1 keeps requesting, client 2 re-requests: grants alternate.
        set_n(1, 4);
        set_n(2, 6);
        cl_req[1] = 1'b1;
        cl_req[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b1, idx);
            chk("alternate", idx, exp_seq[i]);
            if (i < 3 && idx >= 0) cl_req[idx] = 1'b1;
        end
        serve_one(1'b1, idx);

        // Back-to-back engine transactions: second must not finish on the stale ack.
        eng_lat = 4;
        set_n(0, 12);
        set_n(1, 20);
        cl_req[0] = 1'b1;
        cl_req[1] = 1'b1;
        serve_one(1'b1, idx);
        serve_one(1'b1, idx);
        chk("stale_ack_at_issue", ack_at_rise, 1);
        chk("b2b_second_n", pulse_n, int'(cl_n[idx*N_IN +: N_IN]));

        // Client drops its request while waiting: still acked, for exactly one cycle.
        eng_lat = 6;
        set_n(2, 7);
        cl_req[2] = 1'b1;
        tick(4);
        cl_req[2] = 1'b0;
        wait_grant(idx);
        chk("early_drop_idx", idx, 2);
        chk("early_drop_result", cl_result, 13);
        tick(1);
        chk("early_drop_ack_pulse", cl_ack, 0);
        mdl_ptr = 3;

        // Random traffic against the reference.
        for (int r = 0; r < 20; r++) begin
            eng_lat = $urandom_range(1, 6);
            mask    = NUM_CL'($urandom_range(1, (1 << NUM_CL) - 1));
            for (int i = 0; i < NUM_CL; i++) set_n(i, $urandom_range(0, 90));
            @(negedge clk);
            cl_req = mask;
            while (cl_req != '0) serve_one(1'b1, idx);
        end

        // Reset during WAIT_DONE.
        eng_lat = 10;
        set_n(1, 20);
        cl_req[1] = 1'b1;
        tick(5);
        chk("abort_busy", busy, 1);
        chk("abort_fib_req", fib_req, 1);
        chk("abort_no_ack", cl_ack, 0);
        #2;
        rst_n  = 1'b0;
        cl_req = '0;
        #1;
        chk("abort_cl_ack", cl_ack, 0);
        chk("abort_cl_result", cl_result, 0);
        chk("abort_fib_req0", fib_req, 0);
        chk("abort_fib_n", fib_n, 0);
        chk("abort_busy0", busy, 0);
        tick(2);
        rst_n   = 1'b1;
        mdl_ptr = 0;
        eng_lat = 3;
        set_n(2, 5);
        cl_req[2] = 1'b1;
        serve_one(1'b1, idx);
        chk("after_abort_result5", cl_result, 5);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
